hub75_dbuf_framebuffer: RTL and testbench
=========================================

Name: hub75_dbuf_framebuffer

Overview:
Parametrised, single-clock, double-buffered framebuffer for the HUB75 controller. Pixel writer fills the back buffer while the scan engine reads the front buffer, fetching CHANNELS pixels per read (generalises top/bottom halves). Buffer swap is a request/complete handshake, deferred to the scan's frame boundary so the panel never tears.

Parameters:
WIDTH, 64, panel columns (power of two)
HEIGHT, 32, panel rows (power of two, divisible by CHANNELS)
PIXEL_BITS, 16, bits per pixel (RGB565 default)
CHANNELS, 2, parallel row segments read per access (2 = top/bottom)
CLEAR_VALUE, 0, fill value used by the auto-clear feature

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
write_en  in  1  write strobe, back buffer
write_addr  in  AW=log2(WIDTH*HEIGHT)  linear pixel address, row-major
write_data  in  PIXEL_BITS  pixel value
write_ready  out  1  high when writes are accepted
swap_req  in  1  one-cycle request to swap front/back
frame_end  in  1  scan engine marks last read of a frame
swap_pending  out  1  request accepted, awaiting frame_end
swap_done  out  1  one-cycle pulse when swap takes effect
front_sel  out  1  index of buffer currently displayed
read_en  in  1  read strobe, front buffer
read_addr  in  RAW=AW-log2(CHANNELS)  address within one segment
read_data  out  CHANNELS*PIXEL_BITS  channel c in bits [c*PIXEL_BITS +: PIXEL_BITS]
read_valid  out  1  read_data valid

Behaviour:
- Reset values: front_sel=0, swap_pending=0, swap_done=0, read_data=0, read_valid=0, write_ready=1. RAM contents undefined (not reset).
- Storage: 2 buffers x CHANNELS segments, each SEG=WIDTH*HEIGHT/CHANNELS deep. Segment = write_addr[AW-1:RAW], offset = write_addr[RAW-1:0].
- Write: write_en && write_ready at edge -> buffer !front_sel, segment/offset as above. Writes while write_ready=0 are dropped.
- Read: read_en at edge N -> read_data/read_valid at edge N+1 (1-cycle latency); channel c = front[c*SEG+read_addr]. read_valid=0 cycle after read_en=0; read_data holds.
- Swap FSM: IDLE, PENDING (plus CLEAR with feature).
  - IDLE: swap_req && !frame_end -> PENDING. swap_req && frame_end same cycle -> swap immediately.
  - PENDING: frame_end -> swap, back to IDLE. Further swap_req ignored (coalesced).
  - Swap edge: front_sel toggles, swap_done=1 for one cycle, swap_pending clears.
- Read issued in swap cycle returns old front's data; next read returns new front.
- Write in swap cycle lands in old back buffer (i.e. new front).
- frame_end with no pending request: no effect.
- Reset mid-pending: request lost, front_sel=0.
- Addresses wrap naturally; no bounds error.

Optional Feature:
HUB75_FB_AUTOCLEAR_EN
- Defined: swap edge enters CLEAR; counter 0..SEG-1 writes CLEAR_VALUE to all CHANNELS segments of new back buffer in parallel, one offset per cycle (SEG cycles). write_ready=0 during CLEAR; returns 1 the cycle after offset SEG-1. swap_req during CLEAR sets swap_pending; swap only after CLEAR done and a frame_end. Reset aborts clear.
- Undefined: no CLEAR state, write_ready tied 1, back buffer retains old contents.

Decomposition:
- Package hub75_fb_pkg: swap FSM state enum, AW/RAW/SEG localparam functions (clog2-based).
- Sub-module hub75_fb_segment_ram: one simple-dual-port RAM (1 write, 1 registered read), instantiated 2*CHANNELS times.

Test Plan:
- Defaults; write test-bars 0..2047, swap_req+frame_end same cycle -> swap_done pulse, front_sel=1; read addr 0..1023 returns top=img[a], bottom=img[1024+a], one cycle later.
- swap_req at cycle 10, frame_end at cycle 50 -> swap_pending 11..50, front_sel toggles at 51, single swap_done.
- Three swap_req during PENDING -> exactly one swap at frame_end.
- Write 0xBEEF to addr 5 in swap cycle -> visible at read_addr 5 top channel immediately after swap.
- reset asserted while PENDING -> all outputs at reset values, no swap on later frame_end.
- Autoclear build: swap -> write_ready low 1024 cycles, writes dropped; after next swap all reads return CLEAR_VALUE.

Source files
------------

// File: rtl/hub75_fb_pkg.sv
// hub75_fb_pkg
//   Shared types and sizing helpers for the HUB75 double-buffered framebuffer.
//   - swap_state_e : swap handshake FSM states (ST_CLEAR only reached when
//                    HUB75_FB_AUTOCLEAR_EN is defined)
//   - calc_aw      : linear pixel address width, log2(WIDTH*HEIGHT)
//   - calc_raw     : per-segment address width, AW - log2(CHANNELS)
//   - calc_seg     : per-segment depth, WIDTH*HEIGHT/CHANNELS
package hub75_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } swap_state_e;

  function automatic int calc_aw(input int width, input int height);
    return $clog2(width * height);
  endfunction

  function automatic int calc_raw(input int width, input int height, input int channels);
    return $clog2(width * height) - $clog2(channels);
  endfunction

  function automatic int calc_seg(input int width, input int height, input int channels);
    return (width * height) / channels;
  endfunction

endpackage

// File: rtl/hub75_fb_segment_ram.sv
// hub75_fb_segment_ram
//   Simple dual-port RAM: one synchronous write port, one read port with a
//   registered output. The array itself is never reset; only the read
//   register is, so read data comes up as zero.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read strobe and address; rd_data updates one edge later
//   rd_data           : registered read data, holds when rd_en is low
module hub75_fb_segment_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hub75_dbuf_framebuffer.sv
// hub75_dbuf_framebuffer
//   Double-buffered framebuffer for a HUB75 panel. The pixel writer fills the
//   back buffer while the scan engine reads CHANNELS pixels per access from
//   the front buffer. A swap request is held until the scan's frame_end so the
//   panel never shows a half-swapped frame.
//   Optional macro HUB75_FB_AUTOCLEAR_EN: after each swap the new back buffer
//   is filled with CLEAR_VALUE (one offset per cycle, all segments in
//   parallel) while write_ready is held low.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   write_en/addr/data, write_ready : back-buffer pixel write port (row-major)
//   swap_req, frame_end           : swap request and scan frame boundary
//   swap_pending, swap_done       : request accepted / one-cycle swap pulse
//   front_sel                     : index of the displayed buffer
//   read_en/addr, read_data/valid : front-buffer read, one-cycle latency;
//                                   channel c in read_data[c*PIXEL_BITS +: PIXEL_BITS]
module hub75_dbuf_framebuffer
  import hub75_fb_pkg::*;
#(
  parameter int                    WIDTH       = 64,
  parameter int                    HEIGHT      = 32,
  parameter int                    PIXEL_BITS  = 16,
  parameter int                    CHANNELS    = 2,
  parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         write_en,
  input  logic [calc_aw(WIDTH, HEIGHT)-1:0]            write_addr,
  input  logic [PIXEL_BITS-1:0]                        write_data,
  output logic                                         write_ready,
  input  logic                                         swap_req,
  input  logic                                         frame_end,
  output logic                                         swap_pending,
  output logic                                         swap_done,
  output logic                                         front_sel,
  input  logic                                         read_en,
  input  logic [calc_raw(WIDTH, HEIGHT, CHANNELS)-1:0] read_addr,
  output logic [CHANNELS*PIXEL_BITS-1:0]               read_data,
  output logic                                         read_valid
);

  localparam int AW  = calc_aw(WIDTH, HEIGHT);
  localparam int RAW = calc_raw(WIDTH, HEIGHT, CHANNELS);
  localparam int SEG = calc_seg(WIDTH, HEIGHT, CHANNELS);

  swap_state_e state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        swap_pending_q, swap_pending_d;
  logic        swap_done_q, swap_done_d;
  logic        read_valid_q, read_valid_d;
  logic        rd_sel_q, rd_sel_d;
  logic        do_swap;

  logic                  clearing;
  logic                  user_wr;
  logic [RAW-1:0]        clr_addr;
  logic [AW-1:0]         wr_seg;
  logic [RAW-1:0]        ram_waddr;
  logic [PIXEL_BITS-1:0] ram_wdata;
  logic [1:0][CHANNELS-1:0]                 ram_we;
  logic [1:0][CHANNELS-1:0][PIXEL_BITS-1:0] ram_rdata;

`ifdef HUB75_FB_AUTOCLEAR_EN
  logic           write_ready_q, write_ready_d;
  logic [RAW-1:0] clr_cnt_q, clr_cnt_d;

  assign clearing    = (state_q == ST_CLEAR);
  assign clr_addr    = clr_cnt_q;
  assign write_ready = write_ready_q;
`else
  assign clearing    = 1'b0;
  assign clr_addr    = '0;
  assign write_ready = 1'b1;
`endif

  assign user_wr = write_en && write_ready;

  // Swap handshake. A request arriving together with frame_end swaps at once;
  // otherwise it waits in PENDING, and repeat requests there collapse into one.
  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    swap_done_d    = 1'b0;
    do_swap        = 1'b0;
`ifdef HUB75_FB_AUTOCLEAR_EN
    write_ready_d  = write_ready_q;
    clr_cnt_d      = clr_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          if (frame_end) begin
            do_swap = 1'b1;
          end else begin
            state_d        = ST_PENDING;
            swap_pending_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (frame_end) do_swap = 1'b1;
      end
`ifdef HUB75_FB_AUTOCLEAR_EN
      // frame_end is ignored here: a swap must wait for the clear to finish
      // and then see a fresh frame boundary.
      ST_CLEAR: begin
        if (swap_req) swap_pending_d = 1'b1;
        if (clr_cnt_q == RAW'(SEG - 1)) begin
          write_ready_d = 1'b1;
          state_d       = (swap_pending_q || swap_req) ? ST_PENDING : ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + RAW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (do_swap) begin
      front_sel_d    = ~front_sel_q;
      swap_done_d    = 1'b1;
      swap_pending_d = 1'b0;
`ifdef HUB75_FB_AUTOCLEAR_EN
      state_d        = ST_CLEAR;
      clr_cnt_d      = '0;
      write_ready_d  = 1'b0;
`else
      state_d        = ST_IDLE;
`endif
    end
  end

  // Read side: remember which buffer each read came from so a read issued in
  // the swap cycle still returns the old front's data.
  always_comb begin
    read_valid_d = read_en;
    rd_sel_d     = read_en ? front_sel_q : rd_sel_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      read_valid_q   <= 1'b0;
      rd_sel_q       <= 1'b0;
`ifdef HUB75_FB_AUTOCLEAR_EN
      write_ready_q  <= 1'b1;
      clr_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      read_valid_q   <= read_valid_d;
      rd_sel_q       <= rd_sel_d;
`ifdef HUB75_FB_AUTOCLEAR_EN
      write_ready_q  <= write_ready_d;
      clr_cnt_q      <= clr_cnt_d;
`endif
    end
  end

  // Write port steering. Upper address bits pick the segment; the back buffer
  // is always the one not being displayed (front_sel before any swap this edge).
  assign wr_seg = write_addr >> RAW;

  always_comb begin
    ram_waddr = write_addr[RAW-1:0];
    ram_wdata = write_data;
    ram_we    = '0;
    if (clearing) begin
      ram_waddr = clr_addr;
      ram_wdata = CLEAR_VALUE;
      for (int c = 0; c < CHANNELS; c++) ram_we[~front_sel_q][c] = 1'b1;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        ram_we[~front_sel_q][c] = user_wr && (wr_seg == AW'(c));
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    for (genvar c = 0; c < CHANNELS; c++) begin : g_seg
      hub75_fb_segment_ram #(
        .DEPTH (SEG),
        .AW    (RAW),
        .DW    (PIXEL_BITS)
      ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (ram_we[b][c]),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (read_en && (front_sel_q == 1'(b))),
        .rd_addr (read_addr),
        .rd_data (ram_rdata[b][c])
      );
    end
  end

  always_comb begin
    read_data = '0;
    for (int c = 0; c < CHANNELS; c++)
      read_data[c*PIXEL_BITS +: PIXEL_BITS] = ram_rdata[rd_sel_q][c];
  end

  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign read_valid   = read_valid_q;

endmodule

// File: tb/tb_hub75_dbuf_framebuffer.sv
// tb_hub75_dbuf_framebuffer
//   Randomized bench for hub75_dbuf_framebuffer at default parameters.
//   Reads push their expected data into a queue; a negedge monitor pops and
//   compares whenever read_valid is seen. Handshake outputs are compared each
//   cycle against a frame-level reference model. Honors HUB75_FB_AUTOCLEAR_EN.
module tb_hub75_dbuf_framebuffer;
  localparam int WIDTH = 64, HEIGHT = 32, PB = 16, CH = 2;
  localparam int NPIX = WIDTH * HEIGHT, SEG = NPIX / CH, AW = 11, RAW = 10;
  localparam logic [PB-1:0] CLR = '0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write_en = 1'b0, swap_req = 1'b0, frame_end = 1'b0, read_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [PB-1:0] write_data = '0;
  logic [RAW-1:0] read_addr = '0;
  logic write_ready, swap_pending, swap_done, front_sel, read_valid;
  logic [CH*PB-1:0] read_data;

  hub75_dbuf_framebuffer dut (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_ready(write_ready),
    .swap_req(swap_req), .frame_end(frame_end),
    .swap_pending(swap_pending), .swap_done(swap_done), .front_sel(front_sel),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(read_data), .read_valid(read_valid)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, done_cnt = 0;

  // Reference model: whole-buffer images plus swap bookkeeping.
  logic [PB-1:0] mem [2][NPIX];
  bit m_front = 0, m_pend = 0, m_done = 0;
  int m_clr = 0;   // remaining clear cycles (autoclear build only)
  logic [CH*PB-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && swap_done) done_cnt++;
    if (!reset && read_valid) begin
      if (exp_q.size() == 0) chk("spurious_read_valid", 32'd1, 32'd0);
      else chk("read_data", read_data, exp_q.pop_front());
    end
  end

  task automatic idle();
    write_en = 0; swap_req = 0; frame_end = 0; read_en = 0;
  endtask

  // One clock: capture inputs, advance model at the edge, check handshake outputs.
  task automatic step();
    bit we, re, sr, fe;
    logic [AW-1:0] wa;
    logic [PB-1:0] wd;
    logic [RAW-1:0] ra;
    logic [CH*PB-1:0] e;
    we = write_en; re = read_en; sr = swap_req; fe = frame_end;
    wa = write_addr; wd = write_data; ra = read_addr;
    if (re) begin
      for (int c = 0; c < CH; c++) e[c*PB +: PB] = mem[m_front][c*SEG + int'(ra)];
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (we && m_clr == 0) mem[!m_front][wa] = wd;
    m_done = 0;
    if (m_clr > 0) begin
      m_pend |= sr;
      m_clr--;
    end else if ((m_pend || sr) && fe) begin
      m_front = !m_front;
      m_done = 1;
      m_pend = 0;
`ifdef HUB75_FB_AUTOCLEAR_EN
      m_clr = SEG;
      for (int a = 0; a < NPIX; a++) mem[!m_front][a] = CLR;
`endif
    end else if (sr) begin
      m_pend = 1;
    end
    #1;
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    chk("swap_done", 32'(swap_done), 32'(m_done));
    chk("write_ready", 32'(write_ready), 32'(m_clr == 0));
    chk("read_valid", 32'(read_valid), 32'(re));
  endtask

  task automatic wait_ready();
    idle();
    for (int i = 0; i < 3000 && m_clr > 0; i++) step();
  endtask

  task automatic fill_back();
    wait_ready();
    for (int a = 0; a < NPIX; a++) begin
      write_en = 1; write_addr = AW'(a); write_data = PB'($urandom);
      step();
    end
    idle();
  endtask

  task automatic swap_now();
    wait_ready();
    swap_req = 1; frame_end = 1;
    step();
    idle();
  endtask

  initial begin
    int base;
    bit f0;
    // Reset values
    #3;
    chk("rst_front_sel", 32'(front_sel), 0);
    chk("rst_swap_pending", 32'(swap_pending), 0);
    chk("rst_swap_done", 32'(swap_done), 0);
    chk("rst_read_valid", 32'(read_valid), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_write_ready", 32'(write_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // Fill both buffers, show buffer 1, then scan the whole frame.
    fill_back();
    base = done_cnt;
    swap_now();
    step();
    chk("first_swap_count", 32'(done_cnt - base), 1);
    chk("first_swap_front", 32'(front_sel), 1);
    fill_back();
    for (int a = 0; a < SEG; a++) begin
      read_en = 1; read_addr = RAW'(a);
      step();
    end
    idle(); step();

    // Deferred swap: request now, frame_end 40 cycles later.
    wait_ready();
    f0 = front_sel;
    base = done_cnt;
    swap_req = 1; step(); idle();
    for (int i = 0; i < 39; i++) step();
    chk("pending_before_fe", 32'(swap_pending), 1);
    frame_end = 1; step(); idle();
    chk("deferred_front", 32'(front_sel), 32'(!f0));
    step();
    chk("deferred_swap_count", 32'(done_cnt - base), 1);

    // Three requests while pending coalesce into one swap.
    wait_ready();
    base = done_cnt;
    for (int k = 0; k < 3; k++) begin
      swap_req = 1; step(); idle(); step(); step();
    end
    frame_end = 1; step(); idle();
    step(); step();
    chk("coalesce_swap_count", 32'(done_cnt - base), 1);

    // Write in the swap cycle lands in the new front.
    wait_ready();
    swap_req = 1; frame_end = 1;
    write_en = 1; write_addr = 11'd5; write_data = 16'hBEEF;
    step(); idle();
    read_en = 1; read_addr = 10'd5;
    step(); idle();
    chk("swap_cycle_write", 32'(read_data[PB-1:0]), 32'h0000BEEF);
    step();

    // Two swaps with no writes in between, then scan part of the frame.
    swap_now();
    swap_now();
    wait_ready();
    for (int i = 0; i < 64; i++) begin
      read_en = 1; read_addr = RAW'($urandom);
      step();
    end
    idle(); step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      write_en = ($urandom_range(0, 1) == 1);
      write_addr = AW'($urandom);
      write_data = PB'($urandom);
      read_en = ($urandom_range(0, 1) == 1);
      read_addr = RAW'($urandom);
      swap_req = ($urandom_range(0, 39) == 0);
      frame_end = ($urandom_range(0, 29) == 0);
      step();
    end
    idle(); step(); step();

    // Reset while a swap is pending.
    wait_ready();
    if (front_sel == 1'b0) swap_now();
    wait_ready();
    swap_req = 1; step(); idle(); step();
    chk("pending_before_reset", 32'(swap_pending), 1);
    #2 reset = 1;
    #1;
    chk("rst2_front_sel", 32'(front_sel), 0);
    chk("rst2_swap_pending", 32'(swap_pending), 0);
    chk("rst2_swap_done", 32'(swap_done), 0);
    chk("rst2_read_valid", 32'(read_valid), 0);
    chk("rst2_read_data", read_data, 0);
    chk("rst2_write_ready", 32'(write_ready), 1);
    m_front = 0; m_pend = 0; m_done = 0; m_clr = 0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    base = done_cnt;
    frame_end = 1; step(); idle();
    step();
    chk("no_swap_after_reset", 32'(done_cnt - base), 0);
    chk("front_after_reset", 32'(front_sel), 0);

    chk("read_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
